// File: rtl/clock_time_pkg.sv
// Shared definitions for the HH:MM:SS timekeeper: field limits, widths and
// the set-mode state encoding.
// Optional feature macro: CLOCK_TIME_ALARM_EN (adds alarm set states).
package clock_time_pkg;

  localparam int HR_MAX  = 24;
  localparam int MIN_MAX = 60;
  localparam int SEC_MAX = 60;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

`ifdef CLOCK_TIME_ALARM_EN
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    MODE_RUN     = 3'd0,
    MODE_SET_HR  = 3'd1,
    MODE_SET_MIN = 3'd2,
    MODE_SET_AH  = 3'd3,
    MODE_SET_AM  = 3'd4
  } mode_t;
  // Pressing btn_mode in this state returns to RUN with a clean restart.
  localparam mode_t MODE_LAST_SET = MODE_SET_AM;
`else
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;
  localparam mode_t MODE_LAST_SET = MODE_SET_MIN;
`endif

  // Increment with wrap at modulus; 6 bits covers every time field.
  function automatic logic [5:0] inc_mod(input logic [5:0] val, input int modulus);
    if (int'(val) == modulus - 1)
      return 6'd0;
    else
      return val + 6'd1;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Handshake bundle between the button/display side (master) and the
// timekeeper (slave). Alarm signals exist only with CLOCK_TIME_ALARM_EN.
interface clock_time_ctrl_if;
  import clock_time_pkg::*;

  logic              run;
  logic              btn_mode;
  logic              btn_inc;
  logic [HR_W-1:0]   hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [MODE_W-1:0] mode;
  logic              tick;
  logic              blink;
`ifdef CLOCK_TIME_ALARM_EN
  logic              alarm_arm;
  logic              alarm;
`endif

  modport master (
    output run, btn_mode, btn_inc,
    input  hours, minutes, seconds, mode, tick, blink
`ifdef CLOCK_TIME_ALARM_EN
    , output alarm_arm
    , input  alarm
`endif
  );

  modport slave (
    input  run, btn_mode, btn_inc,
    output hours, minutes, seconds, mode, tick, blink
`ifdef CLOCK_TIME_ALARM_EN
    , input  alarm_arm
    , output alarm
`endif
  );

endinterface

// File: rtl/clk_tick_gen.sv
// Prescaler: counts 0..PERIOD-1 while run is high, emitting a one-cycle tick
// at terminal count and a half-period blink level for the display.
module clk_tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick,
  output logic blink
);

  localparam int PERIOD = CLK_FREQ / TICK_HZ;
  localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PERIOD / 2);

  logic [CNT_W-1:0] count;

  // Count while running; restart forces zero even when paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (restart)
      count <= '0;
    else if (run) begin
      if (count == CNT_LAST)
        count <= '0;
      else
        count <= count + 1'b1;
    end
  end

  // Both outputs decode the registered count, so they freeze with it.
  assign tick  = run && (count == CNT_LAST);
  assign blink = (count < CNT_HALF);

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeper with a button-driven set-mode FSM. The prescaler tick
// advances time only in RUN; set states edit one field per btn_inc pulse.
// Optional feature macro: CLOCK_TIME_ALARM_EN (alarm time, arm input, alarm flag).
//
// state        | meaning
// MODE_RUN     | time advances on tick, btn_inc ignored
// MODE_SET_HR  | btn_inc steps hours mod 24, time frozen
// MODE_SET_MIN | btn_inc steps minutes mod 60 and zeroes seconds, time frozen
// MODE_SET_AH  | (alarm build) btn_inc steps alarm hour mod 24
// MODE_SET_AM  | (alarm build) btn_inc steps alarm minute mod 60
module clock_time_ctrl
  import clock_time_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input logic             clk,
  input logic             rst,
  clock_time_ctrl_if.slave bus
);

  mode_t            mode_q;
  logic [HR_W-1:0]  hours_q;
  logic [MIN_W-1:0] minutes_q;
  logic [SEC_W-1:0] seconds_q;

  logic             tick;
  logic             blink;
  logic             restart;

  logic             sec_wrap;
  logic             min_wrap;
  logic [SEC_W-1:0] sec_next;
  logic [MIN_W-1:0] min_next;
  logic [HR_W-1:0]  hr_next;
  logic [HR_W-1:0]  roll_hr;

`ifdef CLOCK_TIME_ALARM_EN
  logic [HR_W-1:0]  alarm_hr;
  logic [MIN_W-1:0] alarm_min;
  logic             alarm_q;
`endif

  // Leaving the last set state restarts the prescaler in the same edge.
  assign restart = bus.btn_mode && (mode_q == MODE_LAST_SET);

  clk_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (bus.run),
    .restart (restart),
    .tick    (tick),
    .blink   (blink)
  );

  // Next-value arithmetic for the time fields, with carry detection.
  always_comb begin
    sec_wrap = (seconds_q == SEC_W'(SEC_MAX - 1));
    min_wrap = (minutes_q == MIN_W'(MIN_MAX - 1));
    sec_next = SEC_W'(inc_mod(6'(seconds_q), SEC_MAX));
    min_next = MIN_W'(inc_mod(6'(minutes_q), MIN_MAX));
    hr_next  = HR_W'(inc_mod(6'(hours_q), HR_MAX));
    roll_hr  = min_wrap ? hr_next : hours_q;
  end

  // Mode FSM and time counters; a mode press takes priority over inc and tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
`ifdef CLOCK_TIME_ALARM_EN
      alarm_hr  <= '0;
      alarm_min <= '0;
`endif
    end else if (bus.btn_mode) begin
      case (mode_q)
        MODE_RUN:     mode_q <= MODE_SET_HR;
        MODE_SET_HR:  mode_q <= MODE_SET_MIN;
`ifdef CLOCK_TIME_ALARM_EN
        MODE_SET_MIN: mode_q <= MODE_SET_AH;
        MODE_SET_AH:  mode_q <= MODE_SET_AM;
        MODE_SET_AM: begin
          mode_q    <= MODE_RUN;
          seconds_q <= '0;
        end
`else
        MODE_SET_MIN: begin
          mode_q    <= MODE_RUN;
          seconds_q <= '0;
        end
`endif
        default:      mode_q <= MODE_RUN;
      endcase
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (tick) begin
            seconds_q <= sec_next;
            if (sec_wrap) begin
              minutes_q <= min_next;
              if (min_wrap)
                hours_q <= hr_next;
            end
          end
        end
        MODE_SET_HR: begin
          if (bus.btn_inc)
            hours_q <= hr_next;
        end
        MODE_SET_MIN: begin
          if (bus.btn_inc) begin
            minutes_q <= min_next;
            seconds_q <= '0;
          end
        end
`ifdef CLOCK_TIME_ALARM_EN
        MODE_SET_AH: begin
          if (bus.btn_inc)
            alarm_hr <= HR_W'(inc_mod(6'(alarm_hr), HR_MAX));
        end
        MODE_SET_AM: begin
          if (bus.btn_inc)
            alarm_min <= MIN_W'(inc_mod(6'(alarm_min), MIN_MAX));
        end
`endif
        default: mode_q <= MODE_RUN;
      endcase
    end
  end

`ifdef CLOCK_TIME_ALARM_EN
  // Alarm raises when the running time rolls into alarm_hr:alarm_min:00 and
  // drops on disarm, a RUN button press, or the following minute rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alarm_q <= 1'b0;
    else if (!bus.alarm_arm || (mode_q == MODE_RUN && (bus.btn_inc || bus.btn_mode)))
      alarm_q <= 1'b0;
    else if (mode_q == MODE_RUN && tick && sec_wrap)
      alarm_q <= (roll_hr == alarm_hr) && (min_next == alarm_min);
  end

  assign bus.alarm = alarm_q;
`endif

  assign bus.hours   = hours_q;
  assign bus.minutes = minutes_q;
  assign bus.seconds = seconds_q;
  assign bus.mode    = mode_q;
  assign bus.tick    = tick;
  assign bus.blink   = blink;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with PERIOD = 10 cycles.
module tb_clock_time_ctrl;
  import clock_time_pkg::*;

`ifdef CLOCK_TIME_ALARM_EN
  localparam int EXIT_PRESSES = 3;
`else
  localparam int EXIT_PRESSES = 1;
`endif

  typedef struct {
    logic run;
    logic bm;
    logic bi;
    int   h;
    int   m;
    int   s;
    int   md;
    logic t;
    logic b;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [24];

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(
    .CLK_FREQ (10),
    .TICK_HZ  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, " hours"},   int'(bus.hours),   h);
    check({name, " minutes"}, int'(bus.minutes), m);
    check({name, " seconds"}, int'(bus.seconds), s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_inc = 1'b1;
      step();
      bus.btn_inc = 1'b0;
    end
  endtask

  task automatic exit_to_run();
    for (int i = 0; i < EXIT_PRESSES; i++) pulse_mode();
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (!bus.tick && n < 20) begin
      step();
      n++;
    end
    if (!bus.tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no tick within %0d cycles", name, n);
    end
    step();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
`ifdef CLOCK_TIME_ALARM_EN
    bus.alarm_arm = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int ticks_seen;
    n_checks = 0;
    n_fail   = 0;

    for (int k = 0; k < 10; k++)
      vecs[k] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0, (k == 9), (k < 5)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 0, 0, 1, 1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1, 0, 1, 1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1, 0, 1, 2, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 2, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 2, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 2, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 2, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1, 1, 0, 2, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check_time("reset", 0, 0, 0);
    check("reset mode",  int'(bus.mode),  0);
    check("reset tick",  int'(bus.tick),  0);
    check("reset blink", int'(bus.blink), 1);

`ifndef CLOCK_TIME_ALARM_EN
    // Table: first tick, blink phase, set-mode edits, exit with coincident tick
    for (int k = 0; k < 24; k++) begin
      bus.run      = vecs[k].run;
      bus.btn_mode = vecs[k].bm;
      bus.btn_inc  = vecs[k].bi;
      #1;
      check($sformatf("vec%0d hours", k),   int'(bus.hours),   vecs[k].h);
      check($sformatf("vec%0d minutes", k), int'(bus.minutes), vecs[k].m);
      check($sformatf("vec%0d seconds", k), int'(bus.seconds), vecs[k].s);
      check($sformatf("vec%0d mode", k),    int'(bus.mode),    vecs[k].md);
      check($sformatf("vec%0d tick", k),    int'(bus.tick),    int'(vecs[k].t));
      check($sformatf("vec%0d blink", k),   int'(bus.blink),   int'(vecs[k].b));
      @(posedge clk);
      #1;
    end
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
`endif

    // Preload 23:59:58 then roll over midnight
    do_reset();
    bus.run = 1'b1;
    pulse_mode();
    pulse_inc(23);
    pulse_mode();
    pulse_inc(59);
    exit_to_run();
    check("preload mode", int'(bus.mode), 0);
    for (int i = 0; i < 58; i++) wait_tick("preload tick");
    check_time("preload", 23, 59, 58);
    wait_tick("roll tick 1");
    check_time("roll 1", 23, 59, 59);
    wait_tick("roll tick 2");
    check_time("roll 2", 0, 0, 0);

    // Hours wrap at 24, ticks frozen in SET_HR, restart on exit mid-count
    do_reset();
    bus.run = 1'b1;
    wait_tick("pre-set tick");
    check("pre-set seconds", int'(bus.seconds), 1);
    pulse_mode();
    pulse_inc(25);
    check("set_hr mode", int'(bus.mode), 1);
    check("hours wrap", int'(bus.hours), 1);
    wait_tick("set_hr tick 1");
    wait_tick("set_hr tick 2");
    check("set_hr frozen seconds", int'(bus.seconds), 1);
    pulse_mode();
    repeat (3) step();
    exit_to_run();
    check("exit mode", int'(bus.mode), 0);
    check_time("exit", 1, 0, 0);
    n = 0;
    while (!bus.tick && n < 20) begin
      step();
      n++;
    end
    check("cycles to tick after restart", n, 9);

    // run=0 for 30 cycles mid-count: frozen count, no tick
    do_reset();
    bus.run = 1'b1;
    repeat (4) step();
    bus.run = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.tick) ticks_seen++;
      step();
    end
    check("ticks while paused", ticks_seen, 0);
    check("blink held while paused", int'(bus.blink), 1);
    check("seconds while paused", int'(bus.seconds), 0);
    bus.run = 1'b1;
    n = 0;
    while (!bus.tick && n < 20) begin
      step();
      n++;
    end
    check("cycles to tick after resume", n, 5);
    step();
    check("seconds after resume", int'(bus.seconds), 1);

    // Asynchronous reset in the middle of SET_MIN
    pulse_mode();
    pulse_inc(3);
    pulse_mode();
    pulse_inc(7);
    check("pre-rst mode", int'(bus.mode), 2);
    check("pre-rst minutes", int'(bus.minutes), 7);
    #2;
    rst = 1'b1;
    #1;
    check_time("async rst", 0, 0, 0);
    check("async rst mode", int'(bus.mode), 0);
    check("async rst blink", int'(bus.blink), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef CLOCK_TIME_ALARM_EN
    // Alarm at 00:01, fires from 00:00:59, cleared by btn_inc in RUN
    do_reset();
    bus.run = 1'b1;
    repeat (3) pulse_mode();
    pulse_mode();
    pulse_inc(1);
    pulse_mode();
    check("alarm run mode", int'(bus.mode), 0);
    bus.alarm_arm = 1'b1;
    for (int i = 0; i < 59; i++) wait_tick("alarm pre tick");
    check_time("alarm pre", 0, 0, 59);
    check("alarm before", int'(bus.alarm), 0);
    wait_tick("alarm tick");
    check_time("alarm hit", 0, 1, 0);
    check("alarm set", int'(bus.alarm), 1);
    pulse_inc(1);
    check("alarm cleared", int'(bus.alarm), 0);
    check("alarm inc ignored", int'(bus.minutes), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
